alu_issue_stage: RTL

- ID/EX issue register that drives the execute-stage ALU.
- Decodes a RV32I instruction into the 4-bit ALU opcode and selects the a/b operands.
- Flags branch compare sense and illegal encodings.
- Holds everything in a valid/ready pipeline register with a one-entry skid buffer, so the ALU sees stable, registered inputs.

---
 rtl/alu_issue_stage.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX issue register for the execute-stage ALU: decodes RV32I into ALU opcode/operands,
// and holds the result in a valid/ready output register backed by a one-entry skid buffer.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic            br_is_branch,
    output logic            br_take_on_zero,
    output logic            illegal
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_IMM    = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011
    } opcode_e;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        alu_op_e         op;
        logic            br;
        logic            take_on_zero;
        logic            ill;
    } entry_t;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;
    entry_t     dec;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    // Shared funct3 map for register and immediate ALU ops; alt selects SUB/SRA.
    function automatic alu_op_e funct3_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  funct3_op = alt ? OP_SUB : OP_ADD;
            3'b001:  funct3_op = OP_SLL;
            3'b010:  funct3_op = OP_SLT;
            3'b011:  funct3_op = OP_SLTU;
            3'b100:  funct3_op = OP_XOR;
            3'b101:  funct3_op = alt ? OP_SRA : OP_SRL;
            3'b110:  funct3_op = OP_OR;
            default: funct3_op = OP_AND;
        endcase
    endfunction

    always_comb begin
        // NOTE: every field gets a default first so no path through the case infers a latch.
        dec   = '0;
        dec.op = OP_ADD;
        legal = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec.a  = rs1_data;
                dec.b  = rs2_data;
                dec.op = funct3_op(funct3, funct7[5]);
                legal  = (funct7 == F7_ZERO) ||
                         ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_IMM: begin
                dec.a  = rs1_data;
                dec.b  = imm;
                dec.op = funct3_op(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001)
                    legal = (funct7 == F7_ZERO);
                else if (funct3 == 3'b101)
                    legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
            end
            OPC_LOAD, OPC_STORE: begin
                dec.a = rs1_data;
                dec.b = imm;
            end
            OPC_LUI: dec.b = imm;
            OPC_AUIPC: begin
                dec.a = pc;
                dec.b = imm;
            end
            OPC_JAL, OPC_JALR: begin
                dec.a = pc;
                dec.b = XLEN'(4);
            end
            OPC_BRANCH: begin
                dec.a  = rs1_data;
                dec.b  = rs2_data;
                dec.br = 1'b1;
                case (funct3)
                    3'b000:  begin dec.op = OP_SUB;  dec.take_on_zero = 1'b1; end
                    3'b001:  begin dec.op = OP_SUB;  dec.take_on_zero = 1'b0; end
                    3'b100:  begin dec.op = OP_SLT;  dec.take_on_zero = 1'b0; end
                    3'b101:  begin dec.op = OP_SLT;  dec.take_on_zero = 1'b1; end
                    3'b110:  begin dec.op = OP_SLTU; dec.take_on_zero = 1'b0; end
                    3'b111:  begin dec.op = OP_SLTU; dec.take_on_zero = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        // Illegal encodings still flow downstream, but as a harmless ADD of zeros.
        if (!legal) begin
            dec     = '0;
            dec.op  = OP_ADD;
            dec.ill = 1'b1;
        end
    end

    entry_t out_q, out_d, skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept, drain;

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid_q && out_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        in_ready_d   = in_ready_q;
        if (skid_valid_q) begin
            // Full: upstream is stalled, so only a drain can make progress.
            if (drain) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
                in_ready_d   = 1'b1;
            end
        end else if (accept) begin
            if (!out_valid_q || drain) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
                in_ready_d   = 1'b0;
            end
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign alu_a           = out_q.a;
    assign alu_b           = out_q.b;
    assign alu_op          = out_q.op;
    assign br_is_branch    = out_q.br;
    assign br_take_on_zero = out_q.take_on_zero;
    assign illegal         = out_q.ill;

endmodule
